// File: rtl/mem_popcount_reader.sv
`default_nettype none
// ============================================================================
// Module   : mem_popcount_reader
// Brief    : Avalon-MM read master that streams a contiguous, wrapping range
//            of words from a fixed-latency on-chip RAM. It issues one read per
//            cycle and accumulates the number of set bits across the range.
// Options  : define MEM_POPCOUNT_ZEROS_EN to add the count_zeros input. When
//            that input is latched high at start, zero bits are counted
//            instead of set bits.
// Revision : 1.0 - initial release
// ============================================================================
module mem_popcount_reader #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 64,
  parameter int READ_LATENCY = 1,
  parameter int CNT_W        = 17
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W:0]     length,
`ifdef MEM_POPCOUNT_ZEROS_EN
  input  logic                count_zeros,
`endif
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    bit_count,
  output logic [ADDR_W-1:0]   m_address,
  output logic                m_chipselect,
  output logic                m_read,
  output logic                m_write,
  output logic [DATA_W/8-1:0] m_byteenable,
  output logic                m_clken,
  input  logic [DATA_W-1:0]   m_readdata
);

  // Largest legal transfer: the whole memory.
  localparam logic [ADDR_W:0] C_DEPTH = {1'b1, {ADDR_W{1'b0}}};
  // Oldest slot of the valid pipeline; the tag there marks readdata as valid.
  localparam logic [READ_LATENCY-1:0] C_TOP = READ_LATENCY'(1) << (READ_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [ADDR_W-1:0]       r_addr;
  logic [ADDR_W:0]         r_remaining;
  logic [READ_LATENCY-1:0] r_vld;
  logic [CNT_W-1:0]        r_acc;
  logic [CNT_W-1:0]        r_bit_count;
  logic [ADDR_W:0]         w_len;
  logic                    w_accept;
  logic                    w_issue;
  logic                    w_tag;
  logic                    w_more;
  logic                    w_cz;
  logic [CNT_W-1:0]        w_pc;
  logic [CNT_W-1:0]        w_add;
  logic [CNT_W-1:0]        w_acc_next;

  assign w_len    = (length > C_DEPTH) ? C_DEPTH : length;
  assign w_accept = (r_state == S_IDLE) && start;
  assign w_issue  = (r_state == S_ISSUE);
  assign w_tag    = r_vld[READ_LATENCY-1];
  // Anything still in flight behind the tag that emerges this cycle.
  assign w_more   = |(r_vld & ~C_TOP);

`ifdef MEM_POPCOUNT_ZEROS_EN
  logic r_cz;

  // Counting mode is frozen for the whole operation at the accepted start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      r_cz <= 1'b0;
    else if (w_accept) r_cz <= count_zeros;
  end

  assign w_cz = r_cz;
`else
  assign w_cz = 1'b0;
`endif

  // Combinational population count of the returning word.
  always_comb begin
    w_pc = '0;
    for (int i = 0; i < DATA_W; i++) begin
      w_pc = w_pc + CNT_W'(m_readdata[i]);
    end
  end

  assign w_add = w_cz ? (CNT_W'(DATA_W) - w_pc) : w_pc;

  // Accumulator value after this edge: cleared on a new start, bumped on a tag.
  always_comb begin
    w_acc_next = r_acc;
    if (w_accept)   w_acc_next = '0;
    else if (w_tag) w_acc_next = r_acc + w_add;
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    w_next       = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    m_read       = 1'b0;
    m_chipselect = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = (w_len == '0) ? S_DONE : S_ISSUE;
      end
      S_ISSUE: begin
        busy         = 1'b1;
        m_read       = 1'b1;
        m_chipselect = 1'b1;
        if (r_remaining == (ADDR_W+1)'(1)) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (!w_more) w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Address and remaining-word counters; the address wraps naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr      <= '0;
      r_remaining <= '0;
    end else if (w_accept) begin
      r_addr      <= base_addr;
      r_remaining <= w_len;
    end else if (w_issue) begin
      r_addr      <= r_addr + ADDR_W'(1);
      r_remaining <= r_remaining - (ADDR_W+1)'(1);
    end
  end

  // Valid pipeline: one tag per issued read, emerging with its readdata.
  generate
    if (READ_LATENCY == 1) begin : g_vld_single
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_vld <= '0;
        else          r_vld <= w_issue;
      end
    end else begin : g_vld_multi
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_vld <= '0;
        else          r_vld <= {r_vld[READ_LATENCY-2:0], w_issue};
      end
    end
  endgenerate

  // Accumulator register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_acc <= '0;
    else          r_acc <= w_acc_next;
  end

  // Result register, updated on entry to DONE so it is valid alongside done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                       r_bit_count <= '0;
    else if ((r_state != S_DONE) && (w_next == S_DONE)) r_bit_count <= w_acc_next;
  end

  assign bit_count    = r_bit_count;
  assign m_address    = r_addr;
  assign m_write      = 1'b0;
  assign m_byteenable = '1;
  assign m_clken      = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_mem_popcount_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_popcount_reader
// Brief    : Self-checking bench for mem_popcount_reader. A behavioural RAM
//            answers reads one cycle later; every result is predicted from
//            the memory contents with plain arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_popcount_reader;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 64;
  localparam int CNT_W  = 17;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk;
  logic              reset_n;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   length;
  logic              count_zeros;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  bit_count;
  logic [ADDR_W-1:0] m_address;
  logic              m_chipselect;
  logic              m_read;
  logic              m_write;
  logic [7:0]        m_byteenable;
  logic              m_clken;
  logic [DATA_W-1:0] m_readdata;

  logic [DATA_W-1:0] mem [DEPTH];

  int n_checks = 0;
  int n_fail   = 0;

  mem_popcount_reader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LATENCY(1), .CNT_W(CNT_W)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .base_addr    (base_addr),
    .length       (length),
`ifdef MEM_POPCOUNT_ZEROS_EN
    .count_zeros  (count_zeros),
`endif
    .busy         (busy),
    .done         (done),
    .bit_count    (bit_count),
    .m_address    (m_address),
    .m_chipselect (m_chipselect),
    .m_read       (m_read),
    .m_write      (m_write),
    .m_byteenable (m_byteenable),
    .m_clken      (m_clken),
    .m_readdata   (m_readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM with registered address: data for a read appears the next cycle.
  initial m_readdata = '0;
  always @(posedge clk) begin
    if (m_read && m_chipselect) m_readdata <= mem[m_address];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Expected total for a request, straight from the memory contents.
  function automatic logic [CNT_W-1:0] model(input int base, input int n, input bit cz);
    int total;
    bit zeros;
    total = 0;
`ifdef MEM_POPCOUNT_ZEROS_EN
    zeros = cz;
`else
    zeros = 1'b0 & cz;
`endif
    for (int i = 0; i < n; i++) begin
      if (zeros) total += DATA_W - $countones(mem[(base + i) % DEPTH]);
      else       total += $countones(mem[(base + i) % DEPTH]);
    end
    return CNT_W'(total);
  endfunction

  // One complete request; disturb adds stray starts while busy and in DONE.
  task automatic run_op(input string name, input int base, input int len,
                        input bit cz, input bit disturb);
    int n, exp_done, reads, seq_err, busy_err, done_cyc;
    logic [CNT_W-1:0] exp_bc;
    n        = (len > DEPTH) ? DEPTH : len;
    exp_bc   = model(base, n, cz);
    exp_done = (n == 0) ? 1 : n + 2;
    @(negedge clk);
    start       = 1'b1;
    base_addr   = ADDR_W'(base);
    length      = (ADDR_W+1)'(len);
    count_zeros = cz;
    @(posedge clk);
    #1;
    start       = 1'b0;
    base_addr   = ADDR_W'($urandom);
    length      = (ADDR_W+1)'($urandom);
    count_zeros = ~cz;
    reads    = 0;
    seq_err  = 0;
    busy_err = 0;
    done_cyc = -1;
    for (int c = 1; c < 3000 && done_cyc < 0; c++) begin
      @(negedge clk);
      if (m_read !== (c <= n)) seq_err++;
      if (m_read) begin
        if (m_address !== ADDR_W'((base + reads) % DEPTH) || !m_chipselect) seq_err++;
        reads++;
      end
      if (busy !== (c < exp_done)) busy_err++;
      if (done) done_cyc = c;
      if (disturb && c == 2) begin
        start     = 1'b1;
        base_addr = ADDR_W'(base + 100);
        length    = 11'd7;
      end
      if (disturb && c == 3) start = 1'b0;
    end
    check({name, "_reads"}, 64'(reads), 64'(n));
    check({name, "_addr_seq"}, 64'(seq_err), 64'd0);
    check({name, "_busy"}, 64'(busy_err), 64'd0);
    check({name, "_done_cycle"}, 64'(done_cyc), 64'(exp_done));
    check({name, "_bit_count"}, 64'(bit_count), 64'(exp_bc));
    if (disturb) begin
      start  = 1'b1;
      length = 11'd5;
    end
    @(negedge clk);
    start = 1'b0;
    check({name, "_done_pulse"}, 64'({done, busy}), 64'd0);
    check({name, "_held"}, 64'(bit_count), 64'(exp_bc));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n     = 1'b0;
    start       = 1'b0;
    base_addr   = '0;
    length      = '0;
    count_zeros = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom, $urandom};
    repeat (2) @(negedge clk);
    check("rst_busy",    64'(busy), 64'd0);
    check("rst_done",    64'(done), 64'd0);
    check("rst_read",    64'({m_read, m_chipselect, m_write}), 64'd0);
    check("rst_addr",    64'(m_address), 64'd0);
    check("rst_count",   64'(bit_count), 64'd0);
    check("const_ports", 64'({m_byteenable, m_clken}), 64'h1FF);
    reset_n = 1'b1;
    @(negedge clk);

    // Mixed patterns from word 0.
    mem[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    mem[1] = 64'h0;
    mem[2] = 64'h1;
    mem[3] = 64'h8000_0000_0000_0001;
    run_op("tp_basic", 0, 4, 1'b0, 1'b0);
    check("tp_basic_const", 64'(bit_count), 64'd67);

    // Zero-length request.
    run_op("tp_len0", 517, 0, 1'b0, 1'b0);
    check("tp_len0_const", 64'(bit_count), 64'd0);

    // Address wrap across the top of memory.
    mem[1022] = 64'hFF;
    mem[1023] = 64'hFF;
    mem[0]    = 64'hFF;
    mem[1]    = 64'hFF;
    run_op("tp_wrap", 1022, 4, 1'b0, 1'b0);
    check("tp_wrap_const", 64'(bit_count), 64'd32);

    // Stray starts while busy and in DONE are ignored.
    run_op("tp_busy_start", 200, 12, 1'b0, 1'b1);

    // Full sweep of an all-ones memory, plus a clamped over-length request.
    for (int i = 0; i < DEPTH; i++) mem[i] = '1;
    run_op("tp_full", 0, 1024, 1'b0, 1'b0);
    check("tp_full_const", 64'(bit_count), 64'd65536);
    run_op("tp_clamp", 300, 2047, 1'b0, 1'b0);

`ifdef MEM_POPCOUNT_ZEROS_EN
    mem[0] = 64'h0;
    mem[1] = 64'hF;
    run_op("tp_zeros", 0, 2, 1'b1, 1'b0);
    check("tp_zeros_const", 64'(bit_count), 64'd124);
`endif

    // Randomized requests against fresh random contents.
    for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom, $urandom} & {$urandom, $urandom};
    for (int k = 0; k < 14; k++) begin
      run_op("rnd", int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 1100)),
             1'($urandom), 1'($urandom));
    end

    // Asynchronous reset in the middle of an issue burst.
    @(negedge clk);
    start     = 1'b1;
    base_addr = 10'd40;
    length    = 11'd30;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("abort_busy",  64'(busy), 64'd0);
    check("abort_read",  64'({m_read, m_chipselect}), 64'd0);
    check("abort_count", 64'(bit_count), 64'd0);
    check("abort_done",  64'(done), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run_op("after_abort", 40, 30, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_popcount_reader.md
Name: mem_popcount_reader

Overview:
- Avalon-MM read master that streams a contiguous range of 64-bit words out of the on-chip memory's slave port and accumulates the number of set bits.
- Sits between the control logic (Nios custom logic or CSR) and the on-chip RAM: it drives address, chipselect, read, byteenable and clken, and consumes readdata.
- Issues one read per cycle (fully pipelined) against the fixed-latency RAM and reports a 17-bit total.

Parameters:
- ADDR_W, 10, word-address width; depth = 2^ADDR_W words.
- DATA_W, 64, data width; must be a multiple of 8.
- READ_LATENCY, 1, clock cycles from a read issue to readdata valid (RAM with registered address, unregistered q).
- CNT_W, 17, accumulator width; holds at least 2^ADDR_W * DATA_W.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- base_addr  in  ADDR_W  first word address.
- length  in  ADDR_W+1  number of words to read (0..2^ADDR_W).
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the result is final.
- bit_count  out  CNT_W  result; held stable until the next accepted start.
- m_address  out  ADDR_W  word address to the memory.
- m_chipselect  out  1  asserted with m_read.
- m_read  out  1  read strobe.
- m_write  out  1  tied 0.
- m_byteenable  out  DATA_W/8  all ones.
- m_clken  out  1  tied 1.
- m_readdata  in  DATA_W  read data from the memory.

Behaviour:
- Reset (asynchronous, any state) values:
  - State goes to IDLE.
  - busy, done, m_read, m_chipselect = 0.
  - m_address = 0; bit_count = 0.
  - Valid pipeline and accumulator are cleared.
  - Aborting mid-operation discards all in-flight data.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start=1 latches base_addr, latches length (values above 2^ADDR_W are clamped to 2^ADDR_W), and clears the accumulator.
  - Go to ISSUE if the latched length > 0, otherwise go directly to DONE.
- ISSUE:
  - m_read = m_chipselect = 1 every cycle.
  - m_address starts at base_addr and increments by 1 per cycle.
  - Address wraps from 2^ADDR_W-1 to 0.
  - The remaining count decrements each cycle. After the cycle that issues the last word, go to DRAIN.
- Valid tracking:
  - A READ_LATENCY-deep shift register tags each issue.
  - When a tag emerges, the accumulator adds popcount(m_readdata) in that same cycle.
- DRAIN:
  - m_read = 0.
  - Wait until the valid pipeline is empty and the final accumulation has registered, then go to DONE.
- DONE:
  - bit_count is loaded with the accumulator; done = 1 for exactly one cycle.
  - Go to IDLE.
- busy = 1 in ISSUE and DRAIN; busy = 0 in IDLE and DONE.
- Timing: start is sampled at edge 0. Reads are issued in cycles 1..N. done is high in cycle N+READ_LATENCY+1 (N=0: done in cycle 1).
- start while not in IDLE is ignored. start in the DONE cycle is also ignored; a new start is accepted the cycle after done.
- Popcount arithmetic:
  - Combinational sum of DATA_W bits, zero-extended to CNT_W.
  - The accumulator never overflows for legal parameters.
- m_address holds its last value when idle. Its value is don't-care when m_read=0.

Optional Feature:
- Macro: MEM_POPCOUNT_ZEROS_EN.
- When defined:
  - Extra input count_zeros (1 bit) is latched at an accepted start.
  - If the latched value is 1, each word adds DATA_W − popcount(word), i.e. zero bits are counted instead.
- When undefined: the port does not exist and only set bits are counted.

Test Plan:
- Words 0..3 preloaded with 0xFFFFFFFFFFFFFFFF, 0x0, 0x1, 0x8000000000000001; base_addr=0, length=4 -> m_read high for exactly 4 cycles, addresses 0,1,2,3; done in cycle 6; bit_count=67.
- length=0, any base -> no m_read; done in cycle 1; bit_count=0.
- base_addr=1022, length=4, words 1022,1023,0,1 each = 0xFF -> addresses 1022,1023,0,1; bit_count=32.
- Full sweep: all 1024 words = all-ones, length=1024 -> bit_count=65536, no overflow; done in cycle 1026.
- start pulsed while busy with different base/length -> ignored; result matches the first request. Then reset_n dropped mid-ISSUE -> busy=0, m_read=0, bit_count=0 immediately. Restart after reset gives the correct count.
- With MEM_POPCOUNT_ZEROS_EN and count_zeros=1: words 0x0 and 0xF, length=2 -> bit_count=124.
